// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and load-clamp helper for the up counter
package counter_pkg;

  localparam int CTR_WIDTH_DEF = 8;

  typedef logic [CTR_WIDTH_DEF-1:0] ctr_t;

  // Operates on 32 bits so every legal WIDTH can share it after zero-extension.
  function automatic logic [31:0] clamp_load(input logic [31:0] d, input logic [31:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/up_counter.sv
// rtl/up_counter.sv - up counter with enable, clamped load and terminal count
// Optional COUNTER_SAT_EN: hold at MAX_VAL instead of wrapping, with a SAT pulse output.
module up_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH   = CTR_WIDTH_DEF,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
`ifdef COUNTER_SAT_EN
  output logic             SAT,
`endif
  output logic [WIDTH-1:0] ctr,
  output logic             TC
);

  logic [WIDTH-1:0] ctr_q, ctr_d;
  logic             at_max;

  assign at_max = (ctr_q == MAX_VAL);

`ifdef COUNTER_SAT_EN
  logic sat_q, sat_d;
`endif

  always_comb begin
    ctr_d = ctr_q;
`ifdef COUNTER_SAT_EN
    sat_d = 1'b0;
`endif
    if (LD) begin
      ctr_d = WIDTH'(clamp_load(32'(D), 32'(MAX_VAL)));
    end else if (EN) begin
      if (at_max) begin
`ifdef COUNTER_SAT_EN
        sat_d = 1'b1;
`else
        ctr_d = '0;
`endif
      end else begin
        ctr_d = ctr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

`ifdef COUNTER_SAT_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign SAT = sat_q;
`endif

  assign ctr = ctr_q;
  assign TC  = at_max;

  // Control strobes must be resolved whenever the counter is out of reset.
  a_ctrl_known: assert property (@(posedge CLK) RST |-> !$isunknown({EN, LD}));

endmodule

// File: tb/tb_up_counter.sv
// tb/tb_up_counter.sv - self-checking bench for up_counter (8-bit default and 4-bit MAX_VAL=9)
module tb_up_counter;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN  = 1'b0;
  logic       LD  = 1'b0;
  logic [7:0] D   = 8'h00;

  logic [7:0] ctr8;
  logic       tc8;
  logic [3:0] ctr4;
  logic       tc4;
`ifdef COUNTER_SAT_EN
  logic       sat8, sat4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  up_counter #(.WIDTH(8)) u_dut8 (
    .CLK(CLK), .RST(RST), .EN(EN), .LD(LD), .D(D),
`ifdef COUNTER_SAT_EN
    .SAT(sat8),
`endif
    .ctr(ctr8), .TC(tc8)
  );

  up_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u_dut4 (
    .CLK(CLK), .RST(RST), .EN(EN), .LD(LD), .D(D[3:0]),
`ifdef COUNTER_SAT_EN
    .SAT(sat4),
`endif
    .ctr(ctr4), .TC(tc4)
  );

  // Reference model: plain integer arithmetic on the documented rules.
  int m8 = 0, m4 = 0;
  bit ms8 = 0, ms4 = 0;
  bit model_valid = 0;

  function automatic int next_val(int cur, int max, bit rst, bit en, bit ld, int d,
                                  output bit sat);
    bit sat_mode;
`ifdef COUNTER_SAT_EN
    sat_mode = 1;
`else
    sat_mode = 0;
`endif
    sat = 0;
    if (!rst) return 0;
    if (ld) return (d > max) ? max : d;
    if (!en) return cur;
    if (sat_mode && cur == max) begin
      sat = 1;
      return cur;
    end
    return (cur + 1) % (max + 1);
  endfunction

  always @(posedge CLK) begin
    bit s8, s4;
    int n8, n4;
    n8 = next_val(m8, 255, RST, EN, LD, int'(D), s8);
    n4 = next_val(m4, 9, RST, EN, LD, int'(D & 8'h0F), s4);
    m8 <= n8;
    m4 <= n4;
    ms8 <= s8;
    ms4 <= s4;
    if (!RST) model_valid <= 1'b1;
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (model_valid) begin
      chk("model ctr8", int'(ctr8), m8);
      chk("model tc8", int'(tc8), int'(m8 == 255));
      chk("model ctr4", int'(ctr4), m4);
      chk("model tc4", int'(tc4), int'(m4 == 9));
`ifdef COUNTER_SAT_EN
      chk("model sat8", int'(sat8), int'(ms8));
      chk("model sat4", int'(sat4), int'(ms4));
`endif
    end
  end

  task automatic cyc(bit rst, bit en, bit ld, logic [7:0] d);
    RST = rst; EN = en; LD = ld; D = d;
    @(posedge CLK);
    #1;
  endtask

  int seq4 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  initial begin
    // Reset overrides load and enable
    cyc(0, 1, 1, 8'h55);
    chk("reset ctr8", int'(ctr8), 0);
    chk("reset tc8", int'(tc8), 0);
    chk("reset ctr4", int'(ctr4), 0);
    chk("reset tc4", int'(tc4), 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'h00);
    chk("hold ctr8", int'(ctr8), 0);

    // Alternating enable: 8 increments over 16 edges
    for (int i = 0; i < 16; i++) begin
      cyc(1, (i % 2) == 0, 0, 8'h00);
      chk("alt ctr8", int'(ctr8), (i / 2) + 1);
    end
    chk("alt end ctr8", int'(ctr8), 8);
    chk("alt end ctr4", int'(ctr4), 8);

    // Wrap at 0xFF
    cyc(1, 0, 1, 8'hFE);
    chk("load FE ctr8", int'(ctr8), 254);
    chk("load FE clamp ctr4", int'(ctr4), 9);
    cyc(1, 1, 0, 8'h00);
    chk("wrap1 ctr8", int'(ctr8), 255);
    chk("wrap1 tc8", int'(tc8), 1);
    cyc(1, 1, 0, 8'h00);
    chk("wrap2 ctr8", int'(ctr8), 0);
    chk("wrap2 tc8", int'(tc8), 0);

    // Custom terminal MAX_VAL=9
    cyc(0, 0, 0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 0, 8'h00);
      chk("seq ctr4", int'(ctr4), seq4[i]);
      chk("seq tc4", int'(tc4), int'(seq4[i] == 9));
    end

    // Load beats enable, oversize load clamps
    cyc(1, 1, 1, 8'h04);
    chk("ld prio ctr4", int'(ctr4), 4);
    chk("ld prio ctr8", int'(ctr8), 4);
    cyc(1, 0, 1, 8'h0C);
    chk("clamp ctr4", int'(ctr4), 9);
    chk("clamp tc4", int'(tc4), 1);
    chk("noclamp ctr8", int'(ctr8), 12);

    // Reset mid-count
    cyc(0, 0, 0, 8'h00);
    for (int i = 0; i < 35; i++) cyc(1, 1, 0, 8'h00);
    chk("count ctr8", int'(ctr8), 8'h23);
    cyc(0, 1, 0, 8'h00);
    chk("midreset ctr8", int'(ctr8), 0);
    chk("midreset ctr4", int'(ctr4), 0);

    // Terminal behaviour with repeated enable at MAX_VAL
    cyc(1, 0, 1, 8'h09);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 8'h00);
`ifdef COUNTER_SAT_EN
      chk("sat hold ctr4", int'(ctr4), 9);
      chk("sat tc4", int'(tc4), 1);
      chk("sat pulse4", int'(sat4), 1);
`else
      chk("term ctr4", int'(ctr4), i);
`endif
    end
    cyc(1, 0, 0, 8'h00);
`ifdef COUNTER_SAT_EN
    chk("sat idle4", int'(sat4), 0);
`endif

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
